// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard control: operand forwarding selects and load-use stall/bubble generation.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module id_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic [4:0]  id_rn,
    input  logic        id_cancel,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        stall,
    output logic        bubble,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] FwdRf   = 2'b00;
    localparam logic [1:0] FwdExe  = 2'b01;
    localparam logic [1:0] FwdMem  = 2'b10;
    localparam logic [1:0] FwdLoad = 2'b11;

    // Shadow copies of the destination fields held in ID/EXE and EXE/MEM.
    logic       exe_wreg_q, exe_m2reg_q;
    logic [4:0] exe_rn_q;
    logic       mem_wreg_q, mem_m2reg_q;
    logic [4:0] mem_rn_q;

    logic       exe_wreg_d, exe_m2reg_d;
    logic [4:0] exe_rn_d;

    logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;

    // Register 0 is hard-wired, so it never matches a producer.
    always_comb begin
        exe_hit_rs = id_use_rs && exe_wreg_q && (exe_rn_q != 5'd0) && (exe_rn_q == id_rs);
        exe_hit_rt = id_use_rt && exe_wreg_q && (exe_rn_q != 5'd0) && (exe_rn_q == id_rt);
        mem_hit_rs = id_use_rs && mem_wreg_q && (mem_rn_q != 5'd0) && (mem_rn_q == id_rs);
        mem_hit_rt = id_use_rt && mem_wreg_q && (mem_rn_q != 5'd0) && (mem_rn_q == id_rt);
    end

    always_comb begin
        fwda = FwdRf;
        if (exe_hit_rs && !exe_m2reg_q) begin
            fwda = FwdExe;
        end else if (mem_hit_rs) begin
            fwda = mem_m2reg_q ? FwdLoad : FwdMem;
        end
    end

    always_comb begin
        fwdb = FwdRf;
        if (exe_hit_rt && !exe_m2reg_q) begin
            fwdb = FwdExe;
        end else if (mem_hit_rt) begin
            fwdb = mem_m2reg_q ? FwdLoad : FwdMem;
        end
    end

    // A cancel squashes the ID instruction, so the PC must not be held.
    always_comb begin
        stall  = !id_cancel && exe_m2reg_q && (exe_hit_rs || exe_hit_rt);
        bubble = stall || id_cancel;
    end

    always_comb begin
        exe_wreg_d  = 1'b0;
        exe_m2reg_d = 1'b0;
        exe_rn_d    = 5'd0;
        if (!bubble) begin
            exe_wreg_d  = id_wreg;
            exe_m2reg_d = id_m2reg;
            exe_rn_d    = id_rn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_wreg_q  <= 1'b0;
            exe_m2reg_q <= 1'b0;
            exe_rn_q    <= 5'd0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            mem_rn_q    <= 5'd0;
        end else begin
            exe_wreg_q  <= exe_wreg_d;
            exe_m2reg_q <= exe_m2reg_d;
            exe_rn_q    <= exe_rn_d;
            mem_wreg_q  <= exe_wreg_q;
            mem_m2reg_q <= exe_m2reg_q;
            mem_rn_q    <= exe_rn_q;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed vector table, reset/counter sequences,
// and randomized traffic against an instruction-history reference model.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_rn;
    logic        id_use_rs, id_use_rt, id_wreg, id_m2reg, id_cancel;
    logic [1:0]  fwda, fwdb;
    logic        stall, bubble;
    logic [15:0] stall_cnt;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    always #5 clk = ~clk;

    id_hazard_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .id_rn     (id_rn),
        .id_cancel (id_cancel),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .stall     (stall),
        .bubble    (bubble),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic       cancel, use_rs, use_rt, wreg, m2reg;
        logic [4:0] rs, rt, rn;
        logic [1:0] fa, fb;
        logic       st, bu;
    } vec_t;

    vec_t tbl[15];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the last two issued instructions (0 = in EXE, 1 = in MEM).
    typedef struct { logic w, m; logic [4:0] rn; } instr_t;
    instr_t      hist[2];
    int unsigned exp_cnt;

    function automatic vec_t mk(input logic cancel, input logic use_rs, input int rs,
                                input logic use_rt, input int rt, input logic wreg,
                                input logic m2reg, input int rn, input int fa, input int fb,
                                input logic st, input logic bu);
        vec_t v;
        v.cancel = cancel; v.use_rs = use_rs; v.rs = 5'(rs); v.use_rt = use_rt;
        v.rt = 5'(rt); v.wreg = wreg; v.m2reg = m2reg; v.rn = 5'(rn);
        v.fa = 2'(fa); v.fb = 2'(fb); v.st = st; v.bu = bu;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_cancel = v.cancel; id_use_rs = v.use_rs; id_rs = v.rs;
        id_use_rt = v.use_rt; id_rt = v.rt; id_wreg = v.wreg;
        id_m2reg = v.m2reg; id_rn = v.rn;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        rst = 1'b0;
        hist[0] = '{w: 1'b0, m: 1'b0, rn: 5'd0};
        hist[1] = '{w: 1'b0, m: 1'b0, rn: 5'd0};
        exp_cnt = 0;
    endtask

    // Most recent in-flight producer wins; a load still in EXE cannot forward.
    function automatic logic [1:0] model_sel(input logic use_r, input logic [4:0] r);
        if (!use_r || r == 5'd0) return 2'b00;
        if (hist[0].w && hist[0].rn == r && !hist[0].m) return 2'b01;
        if (hist[1].w && hist[1].rn == r) return hist[1].m ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        logic dep;
        dep = (id_use_rs && id_rs != 5'd0 && id_rs == hist[0].rn) ||
              (id_use_rt && id_rt != 5'd0 && id_rt == hist[0].rn);
        return !id_cancel && hist[0].w && hist[0].m && dep;
    endfunction

    initial begin
        // Directed pipeline scenario, one row per cycle, starting from empty slots.
        tbl[0]  = mk(0, 1, 1, 1, 2, 1, 0, 3,  0, 0, 0, 0);  // add r3
        tbl[1]  = mk(0, 1, 3, 1, 4, 1, 0, 6,  1, 0, 0, 0);  // sub uses r3 from EXE
        tbl[2]  = mk(0, 1, 3, 1, 6, 0, 0, 0,  2, 1, 0, 0);  // r3 now in MEM, r6 in EXE
        tbl[3]  = mk(0, 1, 0, 0, 0, 1, 1, 5,  0, 0, 0, 0);  // lw r5
        tbl[4]  = mk(0, 1, 1, 1, 5, 1, 0, 8,  0, 0, 1, 1);  // load-use on rt
        tbl[5]  = mk(0, 1, 1, 1, 5, 1, 0, 8,  0, 3, 0, 0);  // retry: load data from MEM
        tbl[6]  = mk(0, 1, 8, 0, 0, 1, 0, 0,  1, 0, 0, 0);  // writer of r0
        tbl[7]  = mk(0, 1, 0, 1, 0, 1, 0, 7,  0, 0, 0, 0);  // r0 never forwards
        tbl[8]  = mk(0, 1, 2, 0, 0, 1, 0, 7,  0, 0, 0, 0);  // second r7 writer
        tbl[9]  = mk(0, 1, 7, 1, 7, 0, 0, 0,  1, 1, 0, 0);  // EXE beats MEM, rs=rt
        tbl[10] = mk(0, 1, 7, 0, 0, 1, 1, 9,  2, 0, 0, 0);  // lw r9
        tbl[11] = mk(1, 1, 9, 0, 0, 1, 0, 10, 0, 0, 0, 1);  // cancel beats load-use
        tbl[12] = mk(0, 1, 9, 1, 10, 0, 0, 0, 3, 0, 0, 0);  // cancelled r10 never issued
        tbl[13] = mk(0, 1, 1, 1, 2, 1, 1, 4,  0, 0, 0, 0);  // lw r4
        tbl[14] = mk(0, 0, 4, 0, 4, 0, 0, 0,  0, 0, 0, 0);  // unused operands: no stall

        rst = 1'b0;
        @(negedge clk);
        do_reset();

        // Right after reset: nothing forwards, bubble follows cancel only.
        drive(mk(1, 1, 3, 1, 3, 1, 1, 3, 0, 0, 0, 0));
        #1;
        check("post_reset_fwda", 16'(fwda), 16'd0);
        check("post_reset_fwdb", 16'(fwdb), 16'd0);
        check("post_reset_stall", 16'(stall), 16'd0);
        check("post_reset_bubble", 16'(bubble), 16'd1);
        check("post_reset_cnt", stall_cnt, 16'd0);
        step();
        do_reset();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("tbl%0d_fwda", i), 16'(fwda), 16'(tbl[i].fa));
            check($sformatf("tbl%0d_fwdb", i), 16'(fwdb), 16'(tbl[i].fb));
            check($sformatf("tbl%0d_stall", i), 16'(stall), 16'(tbl[i].st));
            check($sformatf("tbl%0d_bubble", i), 16'(bubble), 16'(tbl[i].bu));
            step();
        end
        check("tbl_stall_cnt", stall_cnt, CntEn ? 16'd1 : 16'd0);

        // Reset asserted during a load-use stall discards the load.
        do_reset();
        drive(mk(0, 1, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0));
        step();
        drive(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("midrst_stall_before", 16'(stall), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_stall_after", 16'(stall), 16'd0);
        check("midrst_fwdb_after", 16'(fwdb), 16'd0);
        check("midrst_cnt", stall_cnt, 16'd0);

        // Three separate load-use stalls.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(mk(0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0));
            step();
            drive(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0));
            step();
            step();
        end
        check("three_stalls_cnt", stall_cnt, CntEn ? 16'd3 : 16'd0);

        // Randomized traffic over a small register set to force collisions.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic       e_st, e_bu;
            logic [1:0] e_fa, e_fb;
            rst       = ($urandom_range(0, 39) == 0);
            id_cancel = ($urandom_range(0, 7) == 0);
            id_use_rs = 1'($urandom);
            id_use_rt = 1'($urandom);
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            id_rn     = 5'($urandom_range(0, 3));
            id_wreg   = ($urandom_range(0, 3) != 0);
            id_m2reg  = 1'($urandom);
            #1;
            e_fa = model_sel(id_use_rs, id_rs);
            e_fb = model_sel(id_use_rt, id_rt);
            e_st = model_stall();
            e_bu = e_st || id_cancel;
            check("rnd_fwda", 16'(fwda), 16'(e_fa));
            check("rnd_fwdb", 16'(fwdb), 16'(e_fb));
            check("rnd_stall", 16'(stall), 16'(e_st));
            check("rnd_bubble", 16'(bubble), 16'(e_bu));
            check("rnd_cnt", stall_cnt, CntEn ? 16'(exp_cnt) : 16'd0);
            if (rst) begin
                hist[0] = '{w: 1'b0, m: 1'b0, rn: 5'd0};
                hist[1] = '{w: 1'b0, m: 1'b0, rn: 5'd0};
                exp_cnt = 0;
            end else begin
                hist[1] = hist[0];
                hist[0] = e_bu ? '{w: 1'b0, m: 1'b0, rn: 5'd0}
                               : '{w: id_wreg, m: id_m2reg, rn: id_rn};
                if (e_st && exp_cnt < 32'hFFFF) exp_cnt++;
            end
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
